// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: three-way arbiter and address/gap/data/recovery sequencer for the RTC multiplexed bus
// Optional macro RTC_ARB_RR_EN rotates priority between requesters 1 and 2 (requester 0 stays first).
module rtc_bus_arbiter #(
    parameter int PULSE = 4,
    parameter int GAP   = 2,
    parameter int CW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  lock,
    input  logic [2:0]  wr,
    input  logic [23:0] addr_in,
    input  logic [23:0] wdata_in,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        a_d,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in
);
    typedef enum logic [2:0] {IDLE, ADDR, AGAP, DATA, RECOV} state_t;
    localparam logic [CW-1:0] PL = CW'(PULSE - 1);
    localparam logic [CW-1:0] GL = CW'(GAP - 1);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    g, w, sel;
    logic [7:0]    wd;
    logic          wr_q, start;
`ifdef RTC_ARB_RR_EN
    logic ptr;
    assign w = req[0] ? 2'd0 : (req[1] && !(req[2] && ptr)) ? 2'd1 : 2'd2;
    // ptr set means requester 2 goes ahead of requester 1 at the next arbitration
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= 1'b0;
        else if (state == IDLE && |req && w != 2'd0)
            ptr <= (w == 2'd1);
    end
`else
    assign w = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
`endif
    assign sel   = (state == IDLE) ? w : g;
    assign start = (state == IDLE && |req) || (state == RECOV && cnt == GL && lock[g] && req[g]);
    // Transaction sequencer; every output is set one cycle ahead for the phase being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            gnt    <= '0;
            done   <= '0;
            rdata  <= '0;
            busy   <= 1'b0;
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            a_d    <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= '0;
            g      <= '0;
            wd     <= '0;
            wr_q   <= 1'b0;
        end else begin
            done <= '0;
            cnt  <= cnt + 1'b1;
            if (start) begin
                state  <= ADDR;
                cnt    <= '0;
                gnt    <= 3'b001 << sel;
                g      <= sel;
                busy   <= 1'b1;
                cs_n   <= 1'b0;
                wr_n   <= 1'b0;
                rd_n   <= 1'b1;
                a_d    <= 1'b0;
                ad_oe  <= 1'b1;
                ad_out <= addr_in[{sel, 3'b000} +: 8];
                wd     <= wdata_in[{sel, 3'b000} +: 8];
                wr_q   <= wr[sel];
            end else begin
                case (state)
                    IDLE: cnt <= '0;
                    ADDR: if (cnt == PL) begin
                        state <= AGAP;
                        cnt   <= '0;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        ad_oe <= 1'b0;
                    end
                    AGAP: if (cnt == GL) begin
                        state <= DATA;
                        cnt   <= '0;
                        cs_n  <= 1'b0;
                        a_d   <= 1'b1;
                        wr_n  <= !wr_q;
                        rd_n  <= wr_q;
                        ad_oe <= wr_q;
                        if (wr_q) ad_out <= wd;
                    end
                    DATA: if (cnt == PL) begin
                        state <= RECOV;
                        cnt   <= '0;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        rd_n  <= 1'b1;
                        ad_oe <= 1'b0;
                        done  <= (GAP == 1) ? gnt : 3'b000;
                        if (!wr_q) rdata <= ad_in;
                    end
                    RECOV: if (cnt == GL) begin
                        state <= IDLE;
                        cnt   <= '0;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        done <= (cnt == GL - 1'b1) ? gnt : 3'b000;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed and random checks of rtc_bus_arbiter against a transaction-position model
module tb_rtc_bus_arbiter;
    localparam int P = 4;
    localparam int G = 2;
    localparam int T = 2 * P + 2 * G;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, lock, wr, gnt, done;
    logic [23:0] addr_in, wdata_in;
    logic [7:0]  rdata, ad_out, ad_in;
    logic        busy, cs_n, rd_n, wr_n, a_d, ad_oe;

    rtc_bus_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wr(wr),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .done(done),
        .rdata(rdata), .busy(busy), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .a_d(a_d), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit        m_act = 0;
    int        m_pos = 0;
    int        m_g = 0;
    bit        m_wr = 0;
    logic [7:0] m_addr = 0, m_wd = 0, m_rdata = 0;
`ifdef RTC_ARB_RR_EN
    bit m_pref2 = 0;
`endif
    logic [2:0] prev_gnt = 0;
    int order[$];
    int gcnt[3];
    int dcnt[3];
    int run0 = 0, maxrun0 = 0;

    function automatic logic [7:0] sl(input logic [23:0] v, input int i);
        return v[i*8 +: 8];
    endfunction

    function automatic int pick();
        if (req[0]) return 0;
`ifdef RTC_ARB_RR_EN
        if (req[1] && req[2]) return m_pref2 ? 2 : 1;
`endif
        return req[1] ? 1 : 2;
    endfunction

    function automatic int enc();
        int c = 0;
        foreach (order[i]) c = c * 10 + order[i] + 1;
        return c;
    endfunction

    // Reference: a transaction is a run of T cycles; position within it decides every pin
    always @(posedge clk) begin
        if (reset) begin
            m_act   <= 0;
            m_rdata <= 0;
`ifdef RTC_ARB_RR_EN
            m_pref2 <= 0;
`endif
        end else if (m_act) begin
            if (m_pos == 2 * P + G - 1 && !m_wr) m_rdata <= ad_in;
            if (m_pos == T - 1) begin
                if (lock[m_g] && req[m_g]) begin
                    m_pos  <= 0;
                    m_addr <= sl(addr_in, m_g);
                    m_wd   <= sl(wdata_in, m_g);
                    m_wr   <= wr[m_g];
                end else begin
                    m_act <= 0;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end else if (req != 3'b000) begin
            m_act  <= 1;
            m_pos  <= 0;
            m_g    <= pick();
            m_addr <= sl(addr_in, pick());
            m_wd   <= sl(wdata_in, pick());
            m_wr   <= wr[pick()];
`ifdef RTC_ARB_RR_EN
            if (pick() != 0) m_pref2 <= (pick() == 1);
`endif
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit pa, pg, pd, pr;
        pa = m_act && m_pos < P;
        pg = m_act && m_pos >= P && m_pos < P + G;
        pd = m_act && m_pos >= P + G && m_pos < 2 * P + G;
        pr = m_act && m_pos >= 2 * P + G;
        chk("gnt", int'(gnt), m_act ? (1 << m_g) : 0);
        chk("busy", int'(busy), int'(m_act));
        chk("done", int'(done), (m_act && m_pos == T - 1) ? (1 << m_g) : 0);
        chk("cs_n", int'(cs_n), int'(!(pa || pd)));
        chk("wr_n", int'(wr_n), int'(!(pa || (pd && m_wr))));
        chk("rd_n", int'(rd_n), int'(!(pd && !m_wr)));
        chk("ad_oe", int'(ad_oe), int'(pa || (pd && m_wr)));
        chk("rdata", int'(rdata), int'(m_rdata));
        if (!pr) chk("a_d", int'(a_d), int'(!(pa || pg)));
        if (pa) chk("ad_out_addr", int'(ad_out), int'(m_addr));
        if (pd && m_wr) chk("ad_out_data", int'(ad_out), int'(m_wd));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        if (gnt != 3'b000 && prev_gnt == 3'b000) order.push_back(gnt[0] ? 0 : gnt[1] ? 1 : 2);
        run0 = (gnt == 3'b001) ? run0 + 1 : 0;
        if (run0 > maxrun0) maxrun0 = run0;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) gcnt[i]++;
            if (done[i]) dcnt[i]++;
        end
        prev_gnt = gnt;
    endtask

    task automatic wait_done(input int i, input string tag);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (done[i] !== 1'b1 && k < 60);
        chk(tag, int'(done[i]), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 0; lock = 0; wr = 0; addr_in = 0; wdata_in = 0; ad_in = 0;
        do_reset();
        chk("rst_ad_out", int'(ad_out), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_a_d", int'(a_d), 1);

        // single write from requester 1
        gcnt = '{0, 0, 0};
        dcnt = '{0, 0, 0};
        wr = 3'b010; addr_in = 24'h002100; wdata_in = 24'h004900; req = 3'b010;
        wait_done(1, "wr_done");
        req = 0;
        cycle();
        chk("wr_len", gcnt[1], 12);
        chk("wr_ndone", dcnt[1], 1);
        chk("wr_idle_busy", int'(busy), 0);

        // single read from requester 2
        wr = 0; addr_in = 24'h230000; ad_in = 8'h23; req = 3'b100;
        wait_done(2, "rd_done");
        req = 0;
        cycle();
        chk("rd_rdata", int'(rdata), 8'h23);
        chk("rd_ndone", dcnt[2], 1);

        // three-way contention
        order.delete();
        wr = 3'b101; addr_in = 24'h345678; wdata_in = 24'h9abcde; ad_in = 8'h5a; req = 3'b111;
        wait_done(0, "cont_d0");
        req[0] = 0;
        wait_done(1, "cont_d1");
        req[1] = 0;
        wait_done(2, "cont_d2");
        req[2] = 0;
        cycle();
        chk("cont_order", enc(), 123);

        // locked burst from requester 0 while requester 2 waits
        maxrun0 = 0;
        order.delete();
        wr = 3'b001; addr_in = 24'h000002; wdata_in = 24'h000011; lock = 3'b001; req = 3'b101;
        wait_done(0, "burst_d1");
        addr_in[7:0] = 8'h21;
        wait_done(0, "burst_d2");
        addr_in[7:0] = 8'h22;
        wait_done(0, "burst_d3");
        lock = 0; req[0] = 0;
        wait_done(2, "burst_d_r2");
        req = 0;
        cycle();
        chk("burst_run", maxrun0, 36);
        chk("burst_order", enc(), 13);

        // reset in the data phase of a write
        wr = 3'b010; addr_in = 24'h004400; wdata_in = 24'h007700; req = 3'b010;
        for (int i = 0; i < 8; i++) cycle();
        chk("pre_rst_data_phase", int'(a_d), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_oe", int'(ad_oe), 0);
        chk("mid_rst_strobes", int'({cs_n, rd_n, wr_n}), 7);
        chk("mid_rst_done", int'(done), 0);
        wait_done(1, "post_rst_done");
        req = 0;
        cycle();

        // requesters 1 and 2 both held
        do_reset();
        order.delete();
        wr = 0; req = 3'b110;
`ifdef RTC_ARB_RR_EN
        wait_done(1, "rr_a");
        wait_done(2, "rr_b");
        wait_done(1, "rr_c");
        wait_done(2, "rr_d");
        req[0] = 1'b1;
        wait_done(0, "rr_pre0");
        req = 0;
        cycle();
        chk("rr_order", enc(), 23231);
`else
        wait_done(1, "fix_a");
        wait_done(1, "fix_b");
        req[1] = 0;
        wait_done(2, "fix_c");
        req = 0;
        cycle();
        chk("fix_order", enc(), 223);
`endif

        // random traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            cycle();
            req      = 3'($urandom);
            lock     = 3'($urandom);
            wr       = 3'($urandom);
            addr_in  = 24'($urandom);
            wdata_in = 24'($urandom);
            ad_in    = 8'($urandom);
            reset    = ($urandom_range(99) == 0);
        end
        reset = 0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the RTC multiplexed address/data bus between three requesters and sequences each bus transaction.
- Requester 0 is the initialisation sequencer, 1 is the user-write path, 2 is the periodic read path.
- Grants one requester at a time, then drives the address phase, gap, data phase and recovery on the RTC pins.
- Returns a per-requester done pulse and, for reads, the captured data byte.

Parameters:
- PULSE, 4, cycles cs_n plus wr_n/rd_n are held low in each phase (≥1).
- GAP, 2, cycles all strobes are high between the address and data phases, and in recovery (≥1).
- CW, 4, width of the phase cycle counter; must satisfy 2^CW > max(PULSE, GAP).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  3  request per requester, level, held until done
- lock  in  3  keep grant for back-to-back transactions (burst)
- wr  in  3  per requester: 1 = write, 0 = read
- addr_in  in  24  {addr2, addr1, addr0}, 8 bits each
- wdata_in  in  24  {wdata2, wdata1, wdata0}, 8 bits each
- gnt  out  3  one-hot grant, registered
- done  out  3  one-cycle completion pulse to the granted requester
- rdata  out  8  last read byte, held until the next read completes
- busy  out  1  high whenever state is not IDLE
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low
- a_d  out  1  0 = address phase, 1 = data phase
- ad_out  out  8  bus drive value
- ad_oe  out  1  tristate enable for ad_out
- ad_in  in  8  bus sample

Behaviour:
- Reset: state IDLE; cs_n = rd_n = wr_n = 1; a_d = 1; ad_oe = 0; ad_out = 0; gnt = 0; done = 0; rdata = 0; busy = 0; counter = 0. Reset mid-transaction aborts immediately to these values; no done pulse is issued.
- States: IDLE, ADDR, AGAP, DATA, RECOV. All outputs are registered.
- IDLE: when any req is high, the winner is chosen with fixed priority 0 > 1 > 2. On the next cycle gnt = winner's one-hot value, state = ADDR, and addr/wdata/wr are latched from the winner's slice.
- ADDR, PULSE cycles: cs_n = 0, wr_n = 0, a_d = 0, ad_oe = 1, ad_out = latched address.
- AGAP, GAP cycles: all strobes high, a_d = 0, ad_oe = 0.
- DATA, PULSE cycles: cs_n = 0, a_d = 1.
  - Write: wr_n = 0, ad_oe = 1, ad_out = latched data.
  - Read: rd_n = 0, ad_oe = 0; ad_in is captured into rdata on the last DATA cycle.
- RECOV, GAP cycles: strobes high, ad_oe = 0. done[g] is high on the last RECOV cycle only.
- After RECOV:
  - If lock[g] and req[g] are both high on the last RECOV cycle, the grant is kept: next state is ADDR and addr/wdata/wr are re-latched from slice g. There is no IDLE cycle.
  - Otherwise gnt = 0 and state = IDLE, giving a minimum of one idle cycle before re-arbitration.
- Transaction length: 2·PULSE + 2·GAP cycles, which is 12 at the defaults.
- Request latency: req high in cycle N while IDLE → gnt valid and cs_n low in cycle N+1.
- req[g] dropping mid-transaction does not abort; the transaction completes and done[g] still pulses.
- A requester that is not granted is ignored until the next IDLE arbitration. A lower-priority request waits while a higher one holds lock.
- Phase counter counts 0..PULSE-1 or 0..GAP-1 and clears on every state change.
- gnt is never more than one-hot, and gnt is 0 whenever state is IDLE.
- ad_oe and a read strobe (rd_n = 0) are never asserted in the same cycle.

Optional Feature:
- Macro RTC_ARB_RR_EN.
- Defined: requester 0 keeps absolute priority. Between requesters 1 and 2, priority rotates: whichever of them was granted last gets lowest priority at the next arbitration. The rotation pointer resets to "1 first".
- Undefined: fixed priority 0 > 1 > 2 and no pointer register exists.

Test Plan:
- Single write: req = 3'b010, wr[1] = 1, addr1 = 0x21, wdata1 = 0x49 → gnt = 3'b010 one cycle later, then:
  - ADDR: 4 cycles with ad_out = 0x21, a_d = 0.
  - AGAP: 2 cycles.
  - DATA: 4 cycles with ad_out = 0x49, wr_n = 0.
  - RECOV: 2 cycles, done[1] on the 12th.
  - gnt = 0 and busy = 0 on the next cycle.
- Single read: req[2], addr2 = 0x23, ad_in = 0x23 during DATA → rd_n low for 4 cycles, ad_oe = 0 throughout DATA, rdata = 0x23 after the last DATA cycle, done[2] pulses once.
- Contention: req = 3'b111 in the same cycle → order of grants is 0, 1, 2, with one IDLE cycle between each; done pulses in the same order.
- Burst: req[0] and lock[0] held for 3 transactions (addresses 0x02, 0x21, 0x22) while req[2] is high → gnt stays 3'b001 for 36 consecutive cycles with no IDLE cycle; requester 2 is granted only after lock[0] drops.
- Reset during the DATA phase of a write → the next cycle shows all strobes high, ad_oe = 0, gnt = 0, no done; a new request is accepted normally afterwards.
- With RTC_ARB_RR_EN: req[1] and req[2] held continuously → grants alternate 1, 2, 1, 2. Asserting req[0] preempts at the next IDLE arbitration.
